sp_ram_modes: RTL and testbench

SP_RAM_MODES -- requirements
Module: sp_ram_modes

---
 rtl/sp_ram_pkg.sv | 14 +
 rtl/sp_ram_init_seq.sv | 48 ++++
 rtl/sp_ram_modes.sv | 126 ++++++++++++
 tb/tb_sp_ram_modes.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_pkg.sv
// Shared constants for the single-port RAM: read-during-write modes and init FSM states.
package sp_ram_pkg;

   localparam int unsigned READ_FIRST  = 0;
   localparam int unsigned WRITE_FIRST = 1;
   localparam int unsigned NO_CHANGE   = 2;
   localparam int unsigned WRITE_ZERO  = 3;

   typedef enum logic {
      INIT = 1'b0,
      IDLE = 1'b1
   } init_state_e;

endpackage

// File: rtl/sp_ram_init_seq.sv
// Post-reset zero-fill sequencer: sweeps every address once, then stays idle until reset.
module sp_ram_init_seq
   import sp_ram_pkg::*;
#(
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned INIT_CLEAR = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   output logic              init_busy_o,
   output logic [ADDR_W-1:0] init_addr_o,
   output logic              init_we_o
);

   localparam init_state_e RST_STATE = (INIT_CLEAR != 0) ? INIT : IDLE;

   init_state_e       state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= RST_STATE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         INIT: begin
            cnt_d = cnt_q + ADDR_W'(1);
            // Last address of the sweep reached once the counter is all ones.
            if (&cnt_q) state_d = IDLE;
         end
         IDLE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign init_busy_o = (state_q == INIT);
   assign init_we_o   = (state_q == INIT);
   assign init_addr_o = cnt_q;

endmodule

// File: rtl/sp_ram_modes.sv
// Single-port RAM with byte-lane writes, selectable read-during-write behaviour,
// optional output register and an optional post-reset zero-fill sweep.
module sp_ram_modes
   import sp_ram_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned LANE_W     = 4,
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned READ_MODE  = 0,
   parameter int unsigned OUT_REG    = 0,
   parameter int unsigned INIT_CLEAR = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     we,
   input  logic [DATA_W/LANE_W-1:0] be,
   input  logic [ADDR_W-1:0]        addr,
   input  logic [DATA_W-1:0]        di,
   output logic [DATA_W-1:0]        dout,
   output logic                     rd_valid,
   output logic                     init_busy
);

   localparam int unsigned NUM_LANES = DATA_W / LANE_W;
   localparam int unsigned DEPTH     = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [ADDR_W-1:0] init_addr;
   logic              init_we;

   logic              access_c;
   logic              wr_c;
   logic [DATA_W-1:0] rd_word_c;
   logic [DATA_W-1:0] merged_c;
   logic              mem_we_c;
   logic [ADDR_W-1:0] mem_addr_c;
   logic [DATA_W-1:0] mem_wdata_c;

   logic [DATA_W-1:0] dout1_q, dout1_d;
   logic              rv1_q, rv1_d;

   sp_ram_init_seq #(
      .ADDR_W     (ADDR_W),
      .INIT_CLEAR (INIT_CLEAR)
   ) u_init_seq (
      .clk_i       (clk),
      .rst_i       (rst),
      .init_busy_o (init_busy),
      .init_addr_o (init_addr),
      .init_we_o   (init_we)
   );

   assign access_c  = en & ~init_busy;
   assign wr_c      = access_c & we;
   assign rd_word_c = mem_q[addr];

   always_comb begin
      merged_c = rd_word_c;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (be[k]) merged_c[k*LANE_W +: LANE_W] = di[k*LANE_W +: LANE_W];
      end
   end

   // The sweep owns the single memory port while it runs; user accesses are gated off.
   always_comb begin
      mem_we_c    = init_we | wr_c;
      mem_addr_c  = init_we ? init_addr : addr;
      mem_wdata_c = init_we ? '0 : merged_c;
   end

   always_ff @(posedge clk) begin
      if (mem_we_c) mem_q[mem_addr_c] <= mem_wdata_c;
   end

   always_comb begin
      dout1_d = dout1_q;
      rv1_d   = 1'b0;
      if (access_c) begin
         if (we) begin
            case (READ_MODE)
               READ_FIRST:  dout1_d = rd_word_c;
               WRITE_FIRST: dout1_d = merged_c;
               WRITE_ZERO:  dout1_d = '0;
               default:     dout1_d = dout1_q;
            endcase
         end else begin
            dout1_d = rd_word_c;
            rv1_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout1_q <= '0;
         rv1_q   <= 1'b0;
      end else begin
         dout1_q <= dout1_d;
         rv1_q   <= rv1_d;
      end
   end

   if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] dout2_q;
      logic              rv2_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dout2_q <= '0;
            rv2_q   <= 1'b0;
         end else begin
            dout2_q <= dout1_q;
            rv2_q   <= rv1_q;
         end
      end

      assign dout     = dout2_q;
      assign rd_valid = rv2_q;
   end else begin : g_noreg
      assign dout     = dout1_q;
      assign rd_valid = rv1_q;
   end

endmodule

// File: tb/tb_sp_ram_modes.sv
// Bench for sp_ram_modes: six configurations share one stimulus stream and are checked
// every cycle against a per-configuration behavioural memory model.
module tb_sp_ram_modes;

   localparam int NI    = 6;
   localparam int DEPTH = 32;
   localparam int MODE [NI] = '{0, 1, 2, 3, 0, 1};
   localparam int OREG [NI] = '{0, 0, 0, 0, 1, 0};
   localparam int ICLR [NI] = '{1, 1, 1, 1, 1, 0};

   logic       clk = 1'b0;
   logic       rst, en, we;
   logic [1:0] be;
   logic [4:0] addr;
   logic [7:0] di;

   logic [7:0] dout_w [NI];
   logic       rv_w   [NI];
   logic       busy_w [NI];

   int checks = 0;
   int errs   = 0;
   bit chk_on = 1'b0;

   // behavioural model state
   logic [7:0] mem_m [NI][DEPTH];
   logic [1:0] km_m  [NI][DEPTH];
   logic [7:0] s1_d [NI], s2_d [NI];
   bit         s1_v [NI], s2_v [NI];
   bit         s1_k [NI], s2_k [NI];
   int         left_m [NI];

   always #5 clk = ~clk;

   sp_ram_modes #(.READ_MODE(0), .OUT_REG(0), .INIT_CLEAR(1)) u_dut0 (
      .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .di(di),
      .dout(dout_w[0]), .rd_valid(rv_w[0]), .init_busy(busy_w[0]));
   sp_ram_modes #(.READ_MODE(1), .OUT_REG(0), .INIT_CLEAR(1)) u_dut1 (
      .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .di(di),
      .dout(dout_w[1]), .rd_valid(rv_w[1]), .init_busy(busy_w[1]));
   sp_ram_modes #(.READ_MODE(2), .OUT_REG(0), .INIT_CLEAR(1)) u_dut2 (
      .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .di(di),
      .dout(dout_w[2]), .rd_valid(rv_w[2]), .init_busy(busy_w[2]));
   sp_ram_modes #(.READ_MODE(3), .OUT_REG(0), .INIT_CLEAR(1)) u_dut3 (
      .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .di(di),
      .dout(dout_w[3]), .rd_valid(rv_w[3]), .init_busy(busy_w[3]));
   sp_ram_modes #(.READ_MODE(0), .OUT_REG(1), .INIT_CLEAR(1)) u_dut4 (
      .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .di(di),
      .dout(dout_w[4]), .rd_valid(rv_w[4]), .init_busy(busy_w[4]));
   sp_ram_modes #(.READ_MODE(1), .OUT_REG(0), .INIT_CLEAR(0)) u_dut5 (
      .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .di(di),
      .dout(dout_w[5]), .rd_valid(rv_w[5]), .init_busy(busy_w[5]));

   task automatic chk(input string nm, input int idx, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s[%0d] at %0t: got 0x%0h expected 0x%0h", nm, idx, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         s1_d[i] = 8'h00; s2_d[i] = 8'h00;
         s1_v[i] = 1'b0;  s2_v[i] = 1'b0;
         s1_k[i] = 1'b1;  s2_k[i] = 1'b1;
         left_m[i] = (ICLR[i] != 0) ? DEPTH : 0;
      end
   endtask

   // Model: advance each configuration by one clock using the current inputs.
   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NI; i++) begin
            logic [7:0] pre, mrg;
            logic [1:0] pk, mk;
            s2_d[i] = s1_d[i]; s2_v[i] = s1_v[i]; s2_k[i] = s1_k[i];
            if (left_m[i] > 0) begin
               mem_m[i][DEPTH - left_m[i]] = 8'h00;
               km_m[i][DEPTH - left_m[i]]  = 2'b11;
               left_m[i]--;
               s1_v[i] = 1'b0;
            end else if (en) begin
               if (we) begin
                  pre = mem_m[i][addr];
                  pk  = km_m[i][addr];
                  mrg = {be[1] ? di[7:4] : pre[7:4], be[0] ? di[3:0] : pre[3:0]};
                  mk  = pk | be;
                  mem_m[i][addr] = mrg;
                  km_m[i][addr]  = mk;
                  s1_v[i] = 1'b0;
                  case (MODE[i])
                     0: begin s1_d[i] = pre;   s1_k[i] = (pk == 2'b11); end
                     1: begin s1_d[i] = mrg;   s1_k[i] = (mk == 2'b11); end
                     3: begin s1_d[i] = 8'h00; s1_k[i] = 1'b1;          end
                     default: ;
                  endcase
               end else begin
                  s1_d[i] = mem_m[i][addr];
                  s1_k[i] = (km_m[i][addr] == 2'b11);
                  s1_v[i] = 1'b1;
               end
            end else begin
               s1_v[i] = 1'b0;
            end
         end
      end
   end

   // Compare every configuration against the model on each falling edge.
   always @(negedge clk) begin
      if (chk_on && !rst) begin
         for (int i = 0; i < NI; i++) begin
            logic [7:0] ed;
            bit         ev, ek;
            ed = (OREG[i] != 0) ? s2_d[i] : s1_d[i];
            ev = (OREG[i] != 0) ? s2_v[i] : s1_v[i];
            ek = (OREG[i] != 0) ? s2_k[i] : s1_k[i];
            chk("init_busy", i, int'(busy_w[i]), int'(left_m[i] > 0));
            chk("rd_valid", i, int'(rv_w[i]), int'(ev));
            if (ek) chk("dout", i, int'(dout_w[i]), int'(ed));
         end
      end
   end

   task automatic drive(input logic e, input logic w, input logic [1:0] b,
                        input logic [4:0] a, input logic [7:0] d);
      @(negedge clk);
      en = e; we = w; be = b; addr = a; di = d;
   endtask

   // Release reset while hammering a write into address 9, and measure the sweep length.
   task automatic release_and_sweep();
      int n;
      en = 1'b1; we = 1'b1; be = 2'b11; addr = 5'd9; di = 8'hEE;
      @(negedge clk);
      rst = 1'b0;
      chk_on = 1'b1;
      n = 0;
      for (int c = 0; c < 100 && busy_w[0]; c++) begin
         n++;
         @(negedge clk);
      end
      chk("sweep_len", 0, n, 32);
      en = 1'b0; we = 1'b0;
      for (int a = 0; a < DEPTH; a++) drive(1'b1, 1'b0, 2'b00, 5'(a), 8'h00);
      drive(1'b1, 1'b0, 2'b00, 5'd9, 8'h00);
      drive(1'b0, 1'b0, 2'b00, 5'd0, 8'h00);
      chk("init_write_dropped", 0, int'(dout_w[0]), 8'h00);
      chk("init_read_valid", 0, int'(rv_w[0]), 1);
   endtask

   initial begin
      for (int i = 0; i < NI; i++)
         for (int a = 0; a < DEPTH; a++) begin
            mem_m[i][a] = 8'h00;
            km_m[i][a]  = 2'b00;
         end
      rst = 1'b0; en = 1'b0; we = 1'b0; be = 2'b00; addr = 5'd0; di = 8'h00;
      #2 rst = 1'b1;
      model_reset();
      #1;
      for (int i = 0; i < NI; i++) begin
         chk("rst_dout", i, int'(dout_w[i]), 0);
         chk("rst_rd_valid", i, int'(rv_w[i]), 0);
         chk("rst_busy", i, int'(busy_w[i]), ICLR[i]);
      end
      repeat (2) @(negedge clk);
      release_and_sweep();

      // READ_FIRST: second write returns the old word, then a read returns the new one
      drive(1'b1, 1'b1, 2'b11, 5'd3, 8'hA5);
      drive(1'b1, 1'b1, 2'b11, 5'd3, 8'h3C);
      drive(1'b1, 1'b0, 2'b00, 5'd3, 8'h00);
      chk("rf_write_dout", 0, int'(dout_w[0]), 8'hA5);
      chk("rf_write_valid", 0, int'(rv_w[0]), 0);
      drive(1'b0, 1'b0, 2'b00, 5'd0, 8'h00);
      chk("rf_read_dout", 0, int'(dout_w[0]), 8'h3C);
      chk("rf_read_valid", 0, int'(rv_w[0]), 1);

      // WRITE_FIRST with a single lane enabled
      drive(1'b1, 1'b1, 2'b11, 5'd5, 8'hFF);
      drive(1'b1, 1'b1, 2'b01, 5'd5, 8'h12);
      drive(1'b0, 1'b0, 2'b00, 5'd0, 8'h00);
      chk("wf_lane_dout", 1, int'(dout_w[1]), 8'hF2);
      chk("wf_lane_valid", 1, int'(rv_w[1]), 0);

      // NO_CHANGE holds, WRITE_ZERO clears
      drive(1'b1, 1'b1, 2'b11, 5'd7, 8'h5A);
      drive(1'b1, 1'b0, 2'b00, 5'd7, 8'h00);
      drive(1'b1, 1'b1, 2'b11, 5'd7, 8'h99);
      chk("nc_read_dout", 2, int'(dout_w[2]), 8'h5A);
      drive(1'b0, 1'b0, 2'b00, 5'd0, 8'h00);
      chk("nc_write_dout", 2, int'(dout_w[2]), 8'h5A);
      chk("wz_write_dout", 3, int'(dout_w[3]), 8'h00);
      chk("wz_write_valid", 3, int'(rv_w[3]), 0);

      // Output register: two-cycle latency
      drive(1'b1, 1'b0, 2'b00, 5'd3, 8'h00);
      drive(1'b0, 1'b0, 2'b00, 5'd0, 8'h00);
      chk("oreg_t1_valid", 4, int'(rv_w[4]), 0);
      drive(1'b0, 1'b0, 2'b00, 5'd0, 8'h00);
      chk("oreg_t2_dout", 4, int'(dout_w[4]), 8'h3C);
      chk("oreg_t2_valid", 4, int'(rv_w[4]), 1);

      // Reset between the two output stages clears everything at once
      drive(1'b1, 1'b0, 2'b00, 5'd3, 8'h00);
      drive(1'b0, 1'b0, 2'b00, 5'd0, 8'h00);
      @(posedge clk);
      #2;
      chk("pre_rst_valid", 4, int'(rv_w[4]), 1);
      rst = 1'b1;
      model_reset();
      #1;
      chk("async_rst_dout", 4, int'(dout_w[4]), 0);
      chk("async_rst_valid", 4, int'(rv_w[4]), 0);
      chk("async_rst_busy", 4, int'(busy_w[4]), 1);
      release_and_sweep();

      // Random traffic, biased toward a few addresses to stress hazards
      for (int c = 0; c < 800; c++) begin
         logic [4:0] a;
         a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
         drive(($urandom_range(0, 4) != 0), 1'($urandom), 2'($urandom), a, 8'($urandom));
      end
      drive(1'b0, 1'b0, 2'b00, 5'd0, 8'h00);
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errs);
      $finish;
   end

endmodule
